// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter slice.
// Lock FSM encodings and the index-width helper.
package uart_tx_arbiter_pkg;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request
// at or above start_i, wrapping from N-1 back to 0.
module uart_tx_arbiter_rr_pick #(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] start_i,
   output logic         found_o,
   output logic [W-1:0] idx_o
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [W:0]     cand;

   assign dbl     = {req_i, req_i} >> start_i;
   assign rot     = dbl[N-1:0];
   assign found_o = |req_i;

   // Scan downward so the lowest rotated offset wins.
   always_comb begin
      idx_o = '0;
      cand  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = {1'b0, start_i} + (W+1)'(k);
         if (cand >= (W+1)'(N)) cand = cand - (W+1)'(N);
         if (rot[k]) idx_o = cand[W-1:0];
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter for the UART TX FIFO
// write port, with idle-timeout release of a stalled owner.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter  int NREQ    = 2,
   parameter  int TIMEOUT = 255,
   parameter  int TW      = 8,
   localparam int GW      = clog2(NREQ)
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]   req_last,
   output logic [NREQ-1:0]   req_ready,
   input  logic              fifo_full,
   output logic              fifo_wr,
   output logic [7:0]        fifo_wdata,
   output logic [GW-1:0]     grant_id,
   output logic              busy,
   output logic              timeout_evt
);

   logic [0:0]           state_q, state_d;
   logic [GW-1:0]        grant_q, grant_d;
   logic [GW-1:0]        rr_q, rr_d;
   logic [TW-1:0]        cnt_q, cnt_d;
   logic                 tevt_q, tevt_d;
   logic                 pick_found;
   logic [GW-1:0]        pick_idx;
   logic [NREQ-1:0][7:0] data_a;
   logic                 locked, own_valid, own_last, xfer;
   logic [GW-1:0]        nxt_rr;
   logic [TW-1:0]        cnt_inc;

   uart_tx_arbiter_rr_pick #(
      .N (NREQ),
      .W (GW)
   ) u_pick (
      .req_i   (req_valid),
      .start_i (rr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   assign data_a    = req_data;
   assign locked    = (state_q == ST_LOCKED);
   assign own_valid = req_valid[grant_q];
   assign own_last  = req_last[grant_q];
   assign xfer      = locked & own_valid & ~fifo_full;
   assign nxt_rr    = (grant_q == GW'(NREQ - 1)) ? '0
                    : grant_q + GW'(1);
   assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + TW'(1);

   always_comb begin
      req_ready = '0;
      if (locked) req_ready[grant_q] = ~fifo_full;
   end

   assign fifo_wr     = xfer;
   assign fifo_wdata  = locked ? data_a[grant_q] : 8'h00;
   assign grant_id    = grant_q;
   assign busy        = locked;
   assign timeout_evt = tevt_q;

   // Back-pressure (valid held while full) freezes the idle counter.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      tevt_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               state_d = ST_LOCKED;
               grant_d = pick_idx;
               cnt_d   = '0;
            end
         end
         ST_LOCKED: begin
            if (xfer) begin
               cnt_d = '0;
               if (own_last) begin
                  state_d = ST_IDLE;
                  rr_d    = nxt_rr;
               end
            end else if (!own_valid) begin
               if (cnt_inc == TW'(TIMEOUT)) begin
                  state_d = ST_IDLE;
                  rr_d    = nxt_rr;
                  cnt_d   = '0;
                  tevt_d  = 1'b1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         rr_q    <= '0;
         cnt_q   <= '0;
         tevt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         tevt_q  <= tevt_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter (NREQ=2, TIMEOUT=4).
// Directed messages; a monitor pops expected writes/timeouts.
module tb_uart_tx_arbiter;
   import uart_tx_arbiter_pkg::*;

   localparam int NREQ    = 2;
   localparam int TIMEOUT = 4;
   localparam int TW      = 8;
   localparam int GW      = clog2(NREQ);

   logic              HCLK;
   logic              HRESETn;
   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_last;
   logic [NREQ-1:0]   req_ready;
   logic              fifo_full;
   logic              fifo_wr;
   logic [7:0]        fifo_wdata;
   logic [GW-1:0]     grant_id;
   logic              busy;
   logic              timeout_evt;

   typedef struct {
      bit         tout;
      int         gid;
      logic [7:0] d;
   } exp_t;

   exp_t sb_q[$];
   int   tests;
   int   fails;

   uart_tx_arbiter #(
      .NREQ    (NREQ),
      .TIMEOUT (TIMEOUT),
      .TW      (TW)
   ) dut (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .fifo_full   (fifo_full),
      .fifo_wr     (fifo_wr),
      .fifo_wdata  (fifo_wdata),
      .grant_id    (grant_id),
      .busy        (busy),
      .timeout_evt (timeout_evt)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   function automatic void chk(input string nm,
                               input logic [31:0] act,
                               input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h",
                  nm, act, req);
      end
   endfunction

   function automatic void exp_wr(input int g, input logic [7:0] d);
      exp_t e;
      e.tout = 1'b0;
      e.gid  = g;
      e.d    = d;
      sb_q.push_back(e);
   endfunction

   function automatic void exp_to();
      exp_t e;
      e.tout = 1'b1;
      e.gid  = 0;
      e.d    = 8'h00;
      sb_q.push_back(e);
   endfunction

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   // Bytes of msg go out LSB first; n bytes, last flag on the final one.
   task automatic send(input int r, input int n, input logic [31:0] msg);
      for (int i = 0; i < n; i++) begin
         bit acc;
         int cyc;
         req_valid[r]       = 1'b1;
         req_data[8*r +: 8] = msg[8*i +: 8];
         req_last[r]        = (i == n - 1);
         acc = 1'b0;
         cyc = 0;
         while (!acc && cyc < 100) begin
            @(negedge HCLK);
            acc = req_valid[r] & req_ready[r];
            step();
            cyc++;
         end
         chk("accept_in_budget", 32'(acc), 1);
      end
      req_valid[r] = 1'b0;
      req_last[r]  = 1'b0;
   endtask

   // Monitor: every write or timeout pulse must match the queue head.
   initial begin
      exp_t e;
      forever begin
         @(negedge HCLK);
         if (fifo_full) chk("no_wr_while_full", 32'(fifo_wr), 0);
         if (fifo_wr || timeout_evt) begin
            if (sb_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL sb_unexpected: wr=%0b evt=%0b data=0x%0h, required none",
                        fifo_wr, timeout_evt, fifo_wdata);
            end else begin
               e = sb_q.pop_front();
               chk("sb_kind", 32'(timeout_evt), 32'(e.tout));
               if (!e.tout) begin
                  chk("sb_gid", 32'(grant_id), e.gid);
                  chk("sb_data", 32'(fifo_wdata), 32'(e.d));
               end
            end
         end
      end
   end

   initial begin
      tests     = 0;
      fails     = 0;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      fifo_full = 1'b0;
      HRESETn   = 1'b1;
      #1 HRESETn = 1'b0;
      #2;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_grant", 32'(grant_id), 0);
      chk("rst_evt", 32'(timeout_evt), 0);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_wr", 32'(fifo_wr), 0);
      chk("rst_wdata", 32'(fifo_wdata), 0);
      @(negedge HCLK);
      @(negedge HCLK);
      HRESETn = 1'b1;
      step();

      // Single requester, 3-byte message.
      exp_wr(0, 8'h41);
      exp_wr(0, 8'h42);
      exp_wr(0, 8'h0A);
      fork
         send(0, 3, 32'h000A4241);
         begin
            @(negedge HCLK);
            chk("t1_busy_c0", 32'(busy), 0);
            chk("t1_wr_c0", 32'(fifo_wr), 0);
            @(negedge HCLK);
            chk("t1_busy_c1", 32'(busy), 1);
            chk("t1_gid_c1", 32'(grant_id), 0);
            chk("t1_wr_c1", 32'(fifo_wr), 1);
            @(negedge HCLK);
            chk("t1_wr_c2", 32'(fifo_wr), 1);
            @(negedge HCLK);
            chk("t1_wr_c3", 32'(fifo_wr), 1);
            @(negedge HCLK);
            chk("t1_busy_c4", 32'(busy), 0);
            chk("t1_wr_c4", 32'(fifo_wr), 0);
         end
      join
      step();

      // Contention from reset: req0, req1, req0.
      HRESETn = 1'b0;
      #2 HRESETn = 1'b1;
      step();
      exp_wr(0, 8'hA0);
      exp_wr(0, 8'hA1);
      exp_wr(1, 8'hB0);
      exp_wr(1, 8'hB1);
      exp_wr(0, 8'hA2);
      exp_wr(0, 8'hA3);
      fork
         begin
            send(0, 2, 32'h0000A1A0);
            send(0, 2, 32'h0000A3A2);
         end
         send(1, 2, 32'h0000B1B0);
      join
      step();

      // Back-pressure: 10 full cycles mid-message.
      exp_wr(0, 8'hC0);
      exp_wr(0, 8'hC1);
      exp_wr(0, 8'hC2);
      exp_wr(0, 8'hC3);
      fork
         send(0, 4, 32'hC3C2C1C0);
         begin
            repeat (3) @(posedge HCLK);
            #1 fifo_full = 1'b1;
            repeat (10) begin
               @(negedge HCLK);
               chk("bp_ready", 32'(req_ready), 0);
               chk("bp_wr", 32'(fifo_wr), 0);
               chk("bp_evt", 32'(timeout_evt), 0);
            end
            step();
            fifo_full = 1'b0;
            @(negedge HCLK);
            chk("bp_resume_wr", 32'(fifo_wr), 1);
            chk("bp_resume_rdy", 32'(req_ready), 1);
         end
      join
      step();

      // Idle timeout: req1 stalls, req0 waits.
      exp_wr(1, 8'hD0);
      exp_to();
      exp_wr(0, 8'hE0);
      fork
         send(0, 1, 32'h000000E0);
         begin
            req_valid[1]   = 1'b1;
            req_data[15:8] = 8'hD0;
            req_last[1]    = 1'b0;
            @(negedge HCLK);
            chk("to_idle_rdy", 32'(req_ready), 0);
            step();
            @(negedge HCLK);
            chk("to_rdy1", 32'(req_ready), 2);
            step();
            req_valid[1] = 1'b0;
            repeat (4) begin
               @(negedge HCLK);
               chk("to_no_evt_yet", 32'(timeout_evt), 0);
            end
            @(negedge HCLK);
            chk("to_evt", 32'(timeout_evt), 1);
            chk("to_busy_rel", 32'(busy), 0);
            @(negedge HCLK);
            chk("to_evt_once", 32'(timeout_evt), 0);
            chk("to_busy_next", 32'(busy), 1);
            chk("to_gid_next", 32'(grant_id), 0);
         end
      join
      step();

      // Last byte lands on the cycle the counter would hit TIMEOUT.
      exp_wr(1, 8'hF0);
      exp_wr(1, 8'hF1);
      req_valid[1]   = 1'b1;
      req_data[15:8] = 8'hF0;
      req_last[1]    = 1'b0;
      step();
      @(negedge HCLK);
      chk("lc_rdy_f0", 32'(req_ready), 2);
      step();
      req_valid[1] = 1'b0;
      repeat (3) step();
      req_valid[1]   = 1'b1;
      req_data[15:8] = 8'hF1;
      req_last[1]    = 1'b1;
      @(negedge HCLK);
      chk("lc_wr", 32'(fifo_wr), 1);
      chk("lc_evt_c5", 32'(timeout_evt), 0);
      step();
      req_valid[1] = 1'b0;
      req_last[1]  = 1'b0;
      @(negedge HCLK);
      chk("lc_busy", 32'(busy), 0);
      chk("lc_evt_c6", 32'(timeout_evt), 0);
      step();
      @(negedge HCLK);
      chk("lc_evt_c7", 32'(timeout_evt), 0);
      step();

      // Reset mid-message with the pointer parked on req1.
      exp_wr(0, 8'h55);
      send(0, 1, 32'h00000055);
      step();
      exp_wr(1, 8'h60);
      exp_wr(1, 8'h61);
      req_valid[1]   = 1'b1;
      req_data[15:8] = 8'h60;
      req_last[1]    = 1'b0;
      step();
      @(negedge HCLK);
      chk("rm_rdy_b0", 32'(req_ready), 2);
      step();
      req_data[15:8] = 8'h61;
      @(negedge HCLK);
      chk("rm_rdy_b1", 32'(req_ready), 2);
      step();
      req_data[15:8] = 8'h62;
      HRESETn = 1'b0;
      #1;
      chk("rm_busy", 32'(busy), 0);
      chk("rm_ready", 32'(req_ready), 0);
      chk("rm_wr", 32'(fifo_wr), 0);
      chk("rm_gid", 32'(grant_id), 0);
      @(negedge HCLK);
      chk("rm_wr_hold", 32'(fifo_wr), 0);
      req_valid[1] = 1'b0;
      HRESETn      = 1'b1;
      step();
      exp_wr(0, 8'h48);
      exp_wr(1, 8'h49);
      fork
         send(0, 1, 32'h00000048);
         send(1, 1, 32'h00000049);
      join

      for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge HCLK);
      chk("sb_drained", 32'(sb_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single byte-write port of the UART transmit FIFO between NREQ requesters, e.g. the CPU-side AHB UART path and a debug/trace byte source.
- Grants one requester at a time, round-robin, and locks the grant for a whole message (until a byte flagged last), so messages never interleave on RsTx.
- A lock held by an idle owner is released after a programmable idle timeout.
- Sits between the requesters and the TX FIFO write side (wr / w_data / full).

Parameters:
NREQ, 2, number of requesters (1..8)
TIMEOUT, 255, idle cycles allowed to the lock owner before forced release (1..2^TW-1)
TW, 8, width of the idle-timeout counter

Ports:
HCLK  in  1  system clock
HRESETn  in  1  asynchronous active-low reset
req_valid  in  NREQ  requester i has a byte on req_data
req_data  in  8*NREQ  byte of requester i in bits [8i+7:8i]
req_last  in  NREQ  byte of requester i ends its message
req_ready  out  NREQ  byte of requester i accepted this cycle when valid & ready
fifo_full  in  1  TX FIFO full
fifo_wr  out  1  TX FIFO write strobe
fifo_wdata  out  8  TX FIFO write data
grant_id  out  clog2(NREQ) (min 1)  current owner index, valid when busy=1
busy  out  1  a requester holds the lock
timeout_evt  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (asynchronous, HRESETn=0): state IDLE; busy=0, grant_id=0, timeout_evt=0, rr pointer=0, idle counter=0.
- Reset effects: req_ready=0, fifo_wr=0 (combinational, forced low by IDLE); fifo_wdata=0 while not busy.
- States: IDLE and LOCKED; state, grant_id, rr pointer and counter are registered.
- IDLE:
  - req_ready all 0.
  - If any req_valid, select the first valid index searching upward from rr pointer, wrapping at NREQ-1 -> 0.
  - Next edge: LOCKED, grant_id=selected, counter=0.
  - Arbitration costs exactly one cycle; the earliest byte acceptance is the cycle after the request is seen.
- LOCKED, combinational paths:
  - req_ready[grant_id] = ~fifo_full; all other req_ready = 0.
  - xfer = req_valid[grant_id] & ~fifo_full.
  - fifo_wr = xfer; fifo_wdata = req_data of grant_id (zero-latency pass-through, same-cycle wr/data as the FIFO expects).
- LOCKED, on xfer:
  - counter cleared.
  - If req_last[grant_id]: next state IDLE, rr pointer = grant_id+1 modulo NREQ.
- LOCKED, no xfer:
  - req_valid[grant_id]=0: counter increments (saturating).
  - fifo_full=1 with valid high: counter holds; back-pressure is not idleness.
- Timeout:
  - Counter reaching TIMEOUT with no xfer -> next state IDLE, timeout_evt=1 for exactly one cycle, rr pointer = grant_id+1.
  - Any partial message is abandoned; the arbiter does not insert a marker byte.
- Boundary conditions:
  - xfer with last in the same cycle the counter would hit TIMEOUT: normal release, no timeout_evt.
  - Requester drops valid between selection and LOCKED: lock is still granted; the timeout reclaims it.
  - After a release, IDLE lasts one cycle before the next grant; back-to-back messages from the same requester are allowed when it is the only one valid.
  - NREQ=1: grant_id constant 0; rr pointer stays 0.
  - Asynchronous reset mid-message: immediate return to reset state; no fifo_wr glitch beyond the reset edge.
- No byte is ever written while fifo_full=1. At most one fifo_wr per cycle.

Decomposition:
- Shared constants header uart_arb_defs: state encodings ST_IDLE=0, ST_LOCKED=1; a clog2 function/macro for grant_id width.
- One natural sub-module: rr_pick, a combinational round-robin picker.
  - Inputs: req vector, start pointer.
  - Outputs: found, index.
  - Reused later for a UART RX distribution block.
- The FSM, counter and data mux stay in uart_tx_arbiter.

Test Plan:
- Single requester: req0 sends 3 bytes 0x41,0x42,0x0A (last on 0x0A), FIFO not full.
  - Required: busy rises one cycle after valid.
  - Required: fifo_wr on 3 consecutive cycles with those bytes.
  - Required: busy falls after the 0x0A write.
- Contention: req0 and req1 both valid from reset, 2-byte messages each.
  - Required: order req0 msg, req1 msg, req0 msg; no interleaving; grant_id 0,1,0.
- Back-pressure: fifo_full held 1 for 10 cycles mid-message.
  - Required: req_ready=0 and fifo_wr=0 during those cycles.
  - Required: no timeout_evt even with TIMEOUT=4.
  - Required: transfer resumes on the cycle fifo_full drops.
- Idle timeout: TIMEOUT=4; req1 sends 1 non-last byte then drops valid while req0 is waiting.
  - Required: timeout_evt pulses exactly once, 4 idle cycles later.
  - Required: req0 is granted on the following cycle.
- Last coincident with timeout: the last byte is accepted on the cycle the counter reaches TIMEOUT.
  - Required: timeout_evt stays 0; normal release.
- Reset mid-message: assert HRESETn=0 after byte 2 of 5.
  - Required: busy=0, req_ready=0, fifo_wr=0 immediately.
  - Required: after release, arbitration restarts from req0.
